// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: instruction fetch and data ports share one memory.
// A single access is in flight at a time (IDLE -> ACCESS -> RESP). Data
// requests win by default; a fetch wins once data has starved it STARVE_MAX
// times in a row.
module mem_arbiter #(
    parameter int unsigned LAT        = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic        d_valid,
    output logic [63:0] d_rdata,
    output logic [63:0] mem_addr,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned CW = 3;
    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            owner_d_q, owner_d_d;   // 1 = data port owns the access
    logic            sel_hi_q, sel_hi_d;     // fetch wants upper word
    logic            we_q, we_d;
    logic [63:0]     mem_addr_q, mem_addr_d;
    logic [63:0]     mem_wdata_q, mem_wdata_d;
    logic            mem_we_q, mem_we_d;
    logic            if_valid_q, if_valid_d;
    logic            d_valid_q, d_valid_d;
    logic [31:0]     if_data_q, if_data_d;
    logic [63:0]     d_rdata_q, d_rdata_d;
    logic            grant_if_c, grant_d_c;
    logic            starved_c;

    // Byte-lane bits of the PC do not affect the doubleword fetch.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^if_addr[1:0];

    // Next-state, arbitration and capture logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        owner_d_d   = owner_d_q;
        sel_hi_d    = sel_hi_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        if_data_d   = if_data_q;
        d_rdata_d   = d_rdata_q;
        grant_if_c  = 1'b0;
        grant_d_c   = 1'b0;
        starved_c   = (starve_q == SW'(STARVE_MAX));

        unique case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (d_req && !(if_req && starved_c)) begin
                        grant_d_c = 1'b1;
                    end else if (if_req) begin
                        grant_if_c = 1'b1;
                    end
                end
                if (grant_d_c) begin
                    state_d     = ACCESS;
                    cnt_d       = CW'(1);
                    owner_d_d   = 1'b1;
                    we_d        = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_we_d    = d_we;
                    if (if_req && !starved_c) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else if (grant_if_c) begin
                    state_d    = ACCESS;
                    cnt_d      = CW'(1);
                    owner_d_d  = 1'b0;
                    we_d       = 1'b0;
                    sel_hi_d   = if_addr[2];
                    mem_addr_d = {32'b0, if_addr[31:3], 3'b000};
                    starve_d   = '0;
                end
            end
            ACCESS: begin
                if (cnt_q == CW'(LAT)) begin
                    state_d = RESP;
                    if (owner_d_q) begin
                        d_valid_d = 1'b1;
                        d_rdata_d = we_q ? 64'h0 : mem_rdata;
                    end else begin
                        if_valid_d = 1'b1;
                        if_data_d  = sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_d_q   <= 1'b0;
            sel_hi_q    <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_data_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            owner_d_q   <= owner_d_d;
            sel_hi_q    <= sel_hi_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            if_data_q   <= if_data_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Grants are same-cycle pulses in IDLE; everything else comes from registers.
    assign if_ready  = grant_if_c;
    assign d_ready   = grant_d_c;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_data   = if_data_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table on a LAT=1
// instance plus hand sequences for starvation, LAT=3 timing and mid-access reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic [63:0] mem_rdata = '0;

    logic        o1_if_ready, o1_if_valid, o1_d_ready, o1_d_valid, o1_mem_we, o1_busy;
    logic [31:0] o1_if_data;
    logic [63:0] o1_d_rdata, o1_mem_addr, o1_mem_wdata;
    logic        o3_if_ready, o3_if_valid, o3_d_ready, o3_d_valid, o3_mem_we, o3_busy;
    logic [31:0] o3_if_data;
    logic [63:0] o3_d_rdata, o3_mem_addr, o3_mem_wdata;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LAT(1), .STARVE_MAX(4)) u1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(o1_if_ready),
        .if_valid(o1_if_valid), .if_data(o1_if_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(o1_d_ready), .d_valid(o1_d_valid), .d_rdata(o1_d_rdata),
        .mem_addr(o1_mem_addr), .mem_we(o1_mem_we), .mem_wdata(o1_mem_wdata),
        .mem_rdata(mem_rdata), .busy(o1_busy)
    );

    mem_arbiter #(.LAT(3), .STARVE_MAX(4)) u3 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(o3_if_ready),
        .if_valid(o3_if_valid), .if_data(o3_if_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(o3_d_ready), .d_valid(o3_d_valid), .d_rdata(o3_d_rdata),
        .mem_addr(o3_mem_addr), .mem_we(o3_mem_we), .mem_wdata(o3_mem_wdata),
        .mem_rdata(mem_rdata), .busy(o3_busy)
    );

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [63:0] daddr;
        logic [63:0] dwdata;
        logic [63:0] rdata;
        logic        e_irdy;
        logic        e_drdy;
        logic        e_ival;
        logic        e_dval;
        logic        e_busy;
        logic        e_we;
        logic [63:0] e_maddr;
        logic [63:0] e_mwdata;
        logic [31:0] e_idata;
        logic [63:0] e_drdata;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    // Global time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        g [6];
        logic        exp_g [6];
        int          n;
        int          both;

        // Columns: rst ireq iaddr dreq dwe daddr dwdata rdata |
        //          irdy drdy ival dval busy we maddr mwdata idata drdata
        vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 32'h0, 64'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 32'h0, 64'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 64'h0, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 32'h0, 64'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h104, 1'b0, 1'b0, 64'h0, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h100, 64'h0, 32'h0, 64'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0,
                     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h100, 64'h0, 32'hAAAA_BBBB, 64'h0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h48, 64'h0, 64'h0,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h100, 64'h0, 32'hAAAA_BBBB, 64'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h48, 64'h0, 64'h1122_3344_5566_7788,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h48, 64'h0, 32'hAAAA_BBBB, 64'h0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h48, 64'h0, 32'hAAAA_BBBB, 64'h1122_3344_5566_7788};
        vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'h20, 64'h1234, 64'h0,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h48, 64'h0, 32'hAAAA_BBBB, 64'h1122_3344_5566_7788};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h999, 64'h5555, 64'h7777,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h20, 64'h1234, 32'hAAAA_BBBB, 64'h1122_3344_5566_7788};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h999, 64'h5555, 64'h0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h20, 64'h1234, 32'hAAAA_BBBB, 64'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h8000_0103, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h20, 64'h1234, 32'hAAAA_BBBB, 64'h0};
        vecs[12] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_0100, 64'h1234, 32'hAAAA_BBBB, 64'h0};
        vecs[13] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0,
                     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h8000_0100, 64'h1234, 32'hCCCC_DDDD, 64'h0};

        // Initial reset edge so the first table row sees a defined state.
        next_cycle();

        // Per-cycle table on the LAT=1 instance.
        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst; if_req = vecs[i].ireq; if_addr = vecs[i].iaddr;
            d_req = vecs[i].dreq; d_we = vecs[i].dwe; d_addr = vecs[i].daddr;
            d_wdata = vecs[i].dwdata; mem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("row%0d_if_ready", i),  64'(o1_if_ready),  64'(vecs[i].e_irdy));
            chk($sformatf("row%0d_d_ready", i),   64'(o1_d_ready),   64'(vecs[i].e_drdy));
            chk($sformatf("row%0d_if_valid", i),  64'(o1_if_valid),  64'(vecs[i].e_ival));
            chk($sformatf("row%0d_d_valid", i),   64'(o1_d_valid),   64'(vecs[i].e_dval));
            chk($sformatf("row%0d_busy", i),      64'(o1_busy),      64'(vecs[i].e_busy));
            chk($sformatf("row%0d_mem_we", i),    64'(o1_mem_we),    64'(vecs[i].e_we));
            chk($sformatf("row%0d_mem_addr", i),  o1_mem_addr,       vecs[i].e_maddr);
            chk($sformatf("row%0d_mem_wdata", i), o1_mem_wdata,      vecs[i].e_mwdata);
            chk($sformatf("row%0d_if_data", i),   64'(o1_if_data),   64'(vecs[i].e_idata));
            chk($sformatf("row%0d_d_rdata", i),   o1_d_rdata,        vecs[i].e_drdata);
            next_cycle();
        end

        // Starvation: both ports request continuously; expect D D D D F D.
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8;
        n = 0; both = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if (o1_if_ready && o1_d_ready) both++;
            if (o1_d_ready) begin g[n] = 1'b1; n++; end
            else if (o1_if_ready) begin g[n] = 1'b0; n++; end
            next_cycle();
        end
        chk("starve_grant_count", 64'(n), 64'd6);
        chk("starve_onehot", 64'(both), 64'd0);
        for (int k = 0; k < n; k++)
            chk($sformatf("starve_grant%0d_is_data", k), 64'(g[k]), 64'(exp_g[k]));

        // LAT=3 load: valid 4 cycles after grant, data from 3rd ACCESS cycle.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40; mem_rdata = 64'h0;
        @(negedge clk);
        chk("l3_grant", 64'(o3_d_ready), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            d_req = 1'b0; d_addr = 64'h77; mem_rdata = 64'h111 * 64'(k);
            @(negedge clk);
            chk($sformatf("l3_d_valid_t%0d", k), 64'(o3_d_valid), 64'(k == 4));
            if (k <= 3) chk($sformatf("l3_mem_addr_t%0d", k), o3_mem_addr, 64'h40);
            if (k == 4) chk("l3_d_rdata", o3_d_rdata, 64'h333);
        end

        // Reset in the 2nd ACCESS cycle: access dropped, held request regranted.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40; mem_rdata = 64'h5;
        @(negedge clk);
        chk("rst_first_grant", 64'(o3_d_ready), 64'd1);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_no_grant_in_reset", 64'(o3_d_ready), 64'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(o3_busy), 64'd0);
        chk("rst_no_valid", 64'(o3_d_valid), 64'd0);
        chk("rst_d_rdata", o3_d_rdata, 64'h0);
        chk("rst_mem_addr", o3_mem_addr, 64'h0);
        chk("rst_regrant", 64'(o3_d_ready), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            d_req = 1'b0;
            @(negedge clk);
            chk($sformatf("rst_d_valid_t%0d", k), 64'(o3_d_valid), 64'(k == 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 1, memory read latency in cycles (1..7): mem_rdata valid in the LAT-th cycle of an access.
REQ-002 Parameter STARVE_MAX, default 4, maximum consecutive data grants while a fetch waits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  instruction fetch request, held until if_ready.
REQ-006 if_addr  in  32  fetch byte address (PC).
REQ-007 if_ready  out  1  one-cycle grant pulse for the fetch request.
REQ-008 if_valid  out  1  one-cycle pulse: if_data valid.
REQ-009 if_data  out  32  fetched instruction.
REQ-010 d_req  in  1  data request, held until d_ready.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  64  data byte address.
REQ-013 d_wdata  in  64  store data.
REQ-014 d_ready  out  1  one-cycle grant pulse for the data request.
REQ-015 d_valid  out  1  one-cycle completion pulse (loads and stores).
REQ-016 d_rdata  out  64  load data.
REQ-017 mem_addr  out  64  shared memory address.
REQ-018 mem_we  out  1  shared memory write enable.
REQ-019 mem_wdata  out  64  shared memory write data.
REQ-020 mem_rdata  in  64  shared memory read data.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on grant; ACCESS->RESP after LAT cycles (3-bit counter); RESP->IDLE unconditionally.
REQ-023 Grants occur only in IDLE; at most one of if_ready/d_ready is high in any cycle.
REQ-024 Arbitration in IDLE: data wins when both request, unless starve count == STARVE_MAX, in which case fetch wins.
REQ-025 Starve count increments on each data grant while if_req high, clears on any fetch grant, saturates at STARVE_MAX.
REQ-026 Grant cycle captures owner, address, d_we, d_wdata into registers; later input changes have no effect on the in-flight access.
REQ-027 Fetch access: mem_addr = {32'b0, if_addr[31:3], 3'b000}; mem_we = 0.
REQ-028 Data access: mem_addr = d_addr unchanged; mem_wdata = d_wdata; mem_we = d_we in the first ACCESS cycle only.
REQ-029 mem_rdata is registered at the end of the LAT-th ACCESS cycle.
REQ-030 Fetch response: if_data = captured if_addr[2] ? rdata[63:32] : rdata[31:0].
REQ-031 Data response: d_rdata = registered rdata for loads, 64'h0 for stores.
REQ-032 if_valid / d_valid high only in RESP, only for the owner; response data holds until the next RESP.
REQ-033 Latency: grant at cycle T; valid at cycle T+LAT+1; next grant earliest at T+LAT+2.
REQ-034 Outside ACCESS: mem_we = 0; mem_addr and mem_wdata hold their last values.

Reset
REQ-035 reset high at a clock edge forces IDLE, counters 0, and all outputs 0, including mid-access; any in-flight access is dropped without response.
REQ-036 No grant is issued in the cycle reset is high.

Verification
REQ-037 if_req=1, if_addr=0x0000_0104, mem_rdata=0xAAAA_BBBB_CCCC_DDDD, LAT=1 -> if_ready at T, mem_addr=0x100, if_valid at T+2, if_data=0xAAAA_BBBB.
REQ-038 d_req=1, d_we=1, d_addr=0x20, d_wdata=0x1234 -> mem_we high exactly one cycle with mem_addr=0x20 and mem_wdata=0x1234; d_valid at T+2; d_rdata=0.
REQ-039 if_req and d_req held simultaneously, STARVE_MAX=4 -> four data grants, then one fetch grant, then data again.
REQ-040 LAT=3, load d_addr=0x40 -> d_valid exactly 4 cycles after d_ready; d_rdata equals mem_rdata presented in the 3rd ACCESS cycle.
REQ-041 reset asserted in the 2nd ACCESS cycle of LAT=3 -> next cycle IDLE, busy=0, no valid pulse; pending request is regranted after reset drops.
REQ-042 d_addr changed in the cycle after grant -> mem_addr keeps the captured value for the whole access.
